// File: rtl/reg_if_arb.sv
// Two-master register-bus arbiter: IDLE/ISSUE/RD_WAIT access sequencer.
// Define REG_ARB_FIXED_PRIO_EN for fixed m0 priority (default: round-robin).
module reg_if_arb #(
  parameter int RD_LAT = 1
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [11:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmsk,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [11:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmsk,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [11:0] reg_addr,
  output logic        wr_en,
  output logic        rd_en,
  output logic [3:0]  wr_msk,
  output logic [31:0] wr_data,
  input  logic [31:0] rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RD_WAIT
  } state_e;

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        write_q, write_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmsk_q, wmsk_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        pick0, pick1;
  logic        gnt0, gnt1;
  logic        done;

`ifdef REG_ARB_FIXED_PRIO_EN
  always_comb begin
    pick0 = m0_req;
    pick1 = m1_req & ~m0_req;
  end
`else
  logic last_q, last_d;

  // last_q = 1 means m1 holds the most recent grant
  always_comb begin
    pick0 = m0_req & (~m1_req | last_q);
    pick1 = m1_req & (~m0_req | ~last_q);
    last_d = last_q;
    if (gnt0) last_d = 1'b0;
    if (gnt1) last_d = 1'b1;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) last_q <= 1'b1;
    else          last_q <= last_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmsk_d   = wmsk_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt0 = pick0;
        gnt1 = pick1;
        if (pick0) begin
          owner_d = 1'b0;
          write_d = m0_write;
          addr_d  = m0_addr;
          wdata_d = m0_wdata;
          wmsk_d  = m0_wmsk;
          state_d = ISSUE;
        end else if (pick1) begin
          owner_d = 1'b1;
          write_d = m1_write;
          addr_d  = m1_addr;
          wdata_d = m1_wdata;
          wmsk_d  = m1_wmsk;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wr_en   = write_q;
        rd_en   = ~write_q;
        cnt_d   = 2'd0;
        state_d = write_q ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          done    = 1'b1;
          state_d = IDLE;
          if (owner_q) rdata1_d = rd_data;
          else         rdata0_d = rd_data;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmsk_q   <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmsk_q   <= wmsk_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // grant is combinational from req, so mask it while reset is held
  assign m0_gnt    = gnt0 & presetn;
  assign m1_gnt    = gnt1 & presetn;
  assign m0_rvalid = done & ~owner_q;
  assign m1_rvalid = done & owner_q;
  assign m0_rdata  = m0_rvalid ? rd_data : rdata0_q;
  assign m1_rdata  = m1_rvalid ? rd_data : rdata1_q;
  assign reg_addr  = addr_q;
  assign wr_data   = wdata_q;
  assign wr_msk    = wmsk_q;

endmodule

// File: tb/tb_reg_if_arb.sv
// Self-checking bench for reg_if_arb: directed vectors, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_reg_if_arb;

  localparam int LAT = 2;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        m0_req = 0, m0_write = 0;
  logic [11:0] m0_addr = 0;
  logic [31:0] m0_wdata = 0;
  logic [3:0]  m0_wmsk = 0;
  logic        m1_req = 0, m1_write = 0;
  logic [11:0] m1_addr = 0;
  logic [31:0] m1_wdata = 0;
  logic [3:0]  m1_wmsk = 0;
  logic [31:0] rd_data = 0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata, wr_data;
  logic [11:0] reg_addr;
  logic        wr_en, rd_en;
  logic [3:0]  wr_msk;

  int tests = 0;
  int fails = 0;

  always #5 pclk = ~pclk;

  reg_if_arb #(.RD_LAT(LAT)) dut (
    .pclk(pclk), .presetn(presetn),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wmsk(m0_wmsk), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wmsk(m1_wmsk), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .reg_addr(reg_addr), .wr_en(wr_en), .rd_en(rd_en),
    .wr_msk(wr_msk), .wr_data(wr_data), .rd_data(rd_data)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] flags();
    return {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, wr_en, rd_en};
  endfunction

  task automatic next();
    @(posedge pclk);
    #1;
  endtask

  task automatic clr_in();
    m0_req = 0; m0_write = 0; m0_addr = 0; m0_wdata = 0; m0_wmsk = 0;
    m1_req = 0; m1_write = 0; m1_addr = 0; m1_wdata = 0; m1_wmsk = 0;
    rd_data = 0;
  endtask

  task automatic do_reset();
    clr_in();
    presetn = 0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    presetn = 1;
    next();
  endtask

  typedef struct {
    logic        r0, w0;
    logic [11:0] a0;
    logic        r1, w1;
    logic [11:0] a1;
    logic [31:0] wd, rd;
    logic [5:0]  eo;
    logic [11:0] ea;
    logic [31:0] ewd;
    logic [3:0]  em;
    logic [31:0] erd1;
  } vec_t;

  function automatic vec_t mk(
    logic r0, logic w0, logic [11:0] a0,
    logic r1, logic w1, logic [11:0] a1,
    logic [31:0] wd, logic [31:0] rd, logic [5:0] eo,
    logic [11:0] ea, logic [31:0] ewd, logic [3:0] em,
    logic [31:0] erd1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1;
    v.wd = wd; v.rd = rd; v.eo = eo;
    v.ea = ea; v.ewd = ewd; v.em = em; v.erd1 = erd1;
    return v;
  endfunction

  // reference-model state for random traffic
  int          cyc, free_at, strobe_cyc, rv_cyc;
  bit          last_m1, s_wr, rv_own;
  logic [11:0] e_addr;
  logic [31:0] e_wd;
  logic [3:0]  e_msk;
  logic [31:0] e_rd [2];

  initial begin
    vec_t vt [10];
    int   ng;
    int   gc [4];
    bit   go [4];
    bit   eg0, eg1;

    vt[0] = mk(1,1,12'h010, 0,0,12'h000, 32'hA5A50001, 0,
               6'b100000, 12'h000, 32'h0, 4'h0, 32'h0);
    vt[1] = mk(0,0,12'h000, 0,0,12'h000, 32'h0, 0,
               6'b000010, 12'h010, 32'hA5A50001, 4'hF, 32'h0);
    vt[2] = mk(0,0,12'h000, 1,0,12'h020, 32'h0, 0,
               6'b010000, 12'h010, 32'hA5A50001, 4'hF, 32'h0);
    vt[3] = mk(0,0,12'h000, 0,0,12'h000, 32'h0, 0,
               6'b000001, 12'h020, 32'h0, 4'hF, 32'h0);
    vt[4] = mk(0,0,12'h000, 0,0,12'h000, 32'h0, 0,
               6'b000000, 12'h020, 32'h0, 4'hF, 32'h0);
    vt[5] = mk(0,0,12'h000, 0,0,12'h000, 32'h0, 32'h12345678,
               6'b000100, 12'h020, 32'h0, 4'hF, 32'h12345678);
    vt[6] = mk(1,1,12'h030, 1,1,12'h040, 32'h11112222, 0,
               6'b100000, 12'h020, 32'h0, 4'hF, 32'h12345678);
    vt[7] = mk(0,0,12'h000, 1,1,12'h040, 32'h11112222, 0,
               6'b000010, 12'h030, 32'h11112222, 4'hF, 32'h12345678);
    vt[8] = mk(0,0,12'h000, 1,1,12'h040, 32'h11112222, 0,
               6'b010000, 12'h030, 32'h11112222, 4'hF, 32'h12345678);
    vt[9] = mk(0,0,12'h000, 0,0,12'h000, 32'h0, 0,
               6'b000010, 12'h040, 32'h11112222, 4'hF, 32'h12345678);

    // reset state
    #2;
    chk("rst_flags", 64'(flags()), 0);
    chk("rst_addr", 64'(reg_addr), 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    do_reset();

    // directed vectors
    for (int i = 0; i < 10; i++) begin
      m0_req = vt[i].r0; m0_write = vt[i].w0; m0_addr = vt[i].a0;
      m0_wdata = vt[i].wd; m0_wmsk = 4'hF;
      m1_req = vt[i].r1; m1_write = vt[i].w1; m1_addr = vt[i].a1;
      m1_wdata = vt[i].wd; m1_wmsk = 4'hF;
      rd_data = vt[i].rd;
      @(negedge pclk);
      chk($sformatf("vec%0d_flags", i), 64'(flags()), 64'(vt[i].eo));
      chk($sformatf("vec%0d_addr", i), 64'(reg_addr), 64'(vt[i].ea));
      chk($sformatf("vec%0d_wdata", i), 64'(wr_data), 64'(vt[i].ewd));
      chk($sformatf("vec%0d_wmsk", i), 64'(wr_msk), 64'(vt[i].em));
      chk($sformatf("vec%0d_m1rdata", i), 64'(m1_rdata), 64'(vt[i].erd1));
      next();
    end

    // both masters hold write requests for four grants
    do_reset();
    m0_req = 1; m0_write = 1; m1_req = 1; m1_write = 1;
    ng = 0;
    for (int k = 0; k < 4; k++) begin gc[k] = 0; go[k] = 0; end
    for (int c = 0; c < 16 && ng < 4; c++) begin
      @(negedge pclk);
      if (m0_gnt || m1_gnt) begin
        chk("tie_onehot", 64'(m0_gnt & m1_gnt), 0);
        gc[ng] = c;
        go[ng] = m1_gnt;
        ng++;
      end
      next();
    end
    clr_in();
    chk("tie_count", 64'(ng), 4);
    for (int k = 0; k < 4; k++) begin
`ifdef REG_ARB_FIXED_PRIO_EN
      chk($sformatf("tie_owner%0d", k), 64'(go[k]), 0);
`else
      chk($sformatf("tie_owner%0d", k), 64'(go[k]), 64'(k % 2));
`endif
      chk($sformatf("tie_gap%0d", k), 64'(gc[k] - gc[0]), 64'(2 * k));
    end

    // reset during RD_WAIT of an m0 read
    do_reset();
    m0_req = 1; m0_write = 0; m0_addr = 12'h055;
    @(negedge pclk);
    chk("rst_rd_gnt", 64'(flags()), 64'b100000);
    next();
    m0_req = 0;
    @(negedge pclk);
    chk("rst_rd_issue", 64'(flags()), 64'b000001);
    next();
    @(negedge pclk);
    m0_req = 1; m0_addr = 12'h055;
    rd_data = 32'hDEADBEEF;
    #2 presetn = 0;
    #1;
    chk("rst_mid_flags", 64'(flags()), 0);
    chk("rst_mid_regs", {20'h0, reg_addr, wr_data}, 0);
    chk("rst_mid_rdata", {m0_rdata, m1_rdata}, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      chk("rst_hold_flags", 64'(flags()), 0);
    end
    presetn = 1;
    m0_req = 0;
    next();
    m0_req = 1; m0_addr = 12'h066; rd_data = 0;
    @(negedge pclk);
    chk("post_rst_gnt", 64'(flags()), 64'b100000);
    next();
    m0_req = 0;
    @(negedge pclk);
    chk("post_rst_issue", 64'(flags()), 64'b000001);
    chk("post_rst_addr", 64'(reg_addr), 64'h066);
    next();
    @(negedge pclk);
    chk("post_rst_wait", 64'(flags()), 0);
    next();
    rd_data = 32'hCAFEF00D;
    @(negedge pclk);
    chk("post_rst_rv", 64'(flags()), 64'b001000);
    chk("post_rst_rdata", 64'(m0_rdata), 64'hCAFEF00D);
    next();

    // m1 request arriving while m0 read is in flight
    rd_data = 0;
    m0_req = 1; m0_write = 0; m0_addr = 12'h077;
    @(negedge pclk);
    chk("wait_m0_gnt", 64'(flags()), 64'b100000);
    next();
    m0_req = 0;
    m1_req = 1; m1_write = 1; m1_addr = 12'h088;
    for (int c = 1; c <= 3; c++) begin
      @(negedge pclk);
      chk($sformatf("wait_no_m1gnt%0d", c), 64'(m1_gnt), 0);
      if (c == 3) chk("wait_m0_rv", 64'(m0_rvalid), 1);
      next();
    end
    @(negedge pclk);
    chk("wait_m1_gnt", 64'(flags()), 64'b010000);
    next();
    clr_in();

    // randomized traffic vs. reference model
    do_reset();
    cyc = 0; free_at = 0; strobe_cyc = -1; rv_cyc = -1;
    last_m1 = 1; s_wr = 0; rv_own = 0;
    e_addr = 0; e_wd = 0; e_msk = 0; e_rd[0] = 0; e_rd[1] = 0;
    eg0 = 0; eg1 = 0;
    for (int n = 0; n < 600; n++) begin
      if (eg0 || (m0_req && $urandom_range(0, 15) == 0)) m0_req = 0;
      else if (!m0_req && $urandom_range(0, 2) == 0) begin
        m0_req = 1; m0_write = 1'($urandom);
        m0_addr = 12'($urandom); m0_wdata = $urandom;
        m0_wmsk = 4'($urandom);
      end
      if (eg1 || (m1_req && $urandom_range(0, 15) == 0)) m1_req = 0;
      else if (!m1_req && $urandom_range(0, 2) == 0) begin
        m1_req = 1; m1_write = 1'($urandom);
        m1_addr = 12'($urandom); m1_wdata = $urandom;
        m1_wmsk = 4'($urandom);
      end
      rd_data = $urandom;
      @(negedge pclk);
      eg0 = 0; eg1 = 0;
      if (cyc >= free_at) begin
        if (m0_req && m1_req) begin
`ifdef REG_ARB_FIXED_PRIO_EN
          eg0 = 1;
`else
          eg0 = last_m1;
          eg1 = !last_m1;
`endif
        end else begin
          eg0 = m0_req;
          eg1 = m1_req;
        end
      end
      chk("rnd_gnt", {m0_gnt, m1_gnt}, {eg0, eg1});
      chk("rnd_strobe", {wr_en, rd_en},
          {cyc == strobe_cyc && s_wr, cyc == strobe_cyc && !s_wr});
      chk("rnd_regs", {reg_addr, wr_data, wr_msk}, {e_addr, e_wd, e_msk});
      if (cyc == rv_cyc) e_rd[rv_own] = rd_data;
      chk("rnd_rv",
          {m0_rvalid, m1_rvalid, m0_rdata, m1_rdata},
          {cyc == rv_cyc && !rv_own, cyc == rv_cyc && rv_own,
           e_rd[0], e_rd[1]});
      if (eg0 || eg1) begin
        s_wr   = eg0 ? m0_write : m1_write;
        e_addr = eg0 ? m0_addr : m1_addr;
        e_wd   = eg0 ? m0_wdata : m1_wdata;
        e_msk  = eg0 ? m0_wmsk : m1_wmsk;
        strobe_cyc = cyc + 1;
        free_at = cyc + (s_wr ? 2 : 2 + LAT);
        if (!s_wr) begin
          rv_cyc = cyc + 1 + LAT;
          rv_own = eg1;
        end
        last_m1 = eg1;
      end
      cyc++;
      next();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_if_arb.md
REG_IF_ARB -- requirements
Module: reg_if_arb

Interface
REQ-001 SHALL have parameter RD_LAT, default 1: cycles from rd_en to valid rd_data; legal range 1..4.
REQ-002 SHALL have port pclk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port presetn, input, 1: asynchronous active-low reset.
REQ-004 SHALL have ports m0_req / m1_req, input, 1: access request, held until gnt.
REQ-005 SHALL have ports m0_write / m1_write, input, 1: 1 = write, 0 = read.
REQ-006 SHALL have ports m0_addr / m1_addr, input, 12: register address.
REQ-007 SHALL have ports m0_wdata / m1_wdata, input, 32: write data.
REQ-008 SHALL have ports m0_wmsk / m1_wmsk, input, 4: byte write mask.
REQ-009 SHALL have ports m0_gnt / m1_gnt, output, 1: command accepted this cycle.
REQ-010 SHALL have ports m0_rvalid / m1_rvalid, output, 1: one-cycle read-data strobe.
REQ-011 SHALL have ports m0_rdata / m1_rdata, output, 32: read data.
REQ-012 SHALL have port reg_addr, output, 12: shared register address.
REQ-013 SHALL have port wr_en, output, 1: register write strobe.
REQ-014 SHALL have port rd_en, output, 1: register read strobe.
REQ-015 SHALL have port wr_msk, output, 4: byte mask for the write.
REQ-016 SHALL have port wr_data, output, 32: write data.
REQ-017 SHALL have port rd_data, input, 32: register read data.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE and RD_WAIT.
REQ-019 IDLE: SHALL assert mN_gnt combinationally for exactly one requester with mN_req=1; no gnt in any other state.
REQ-020 On the gnt edge SHALL capture write, addr, wdata, wmsk and owner, then move to ISSUE.
REQ-021 ISSUE (one cycle): SHALL assert wr_en (write) or rd_en (read), never both; write goes to IDLE, read goes to RD_WAIT.
REQ-022 RD_WAIT: SHALL count RD_LAT cycles after the rd_en cycle, then sample rd_data into owner rdata, pulse owner rvalid for one cycle and return to IDLE.
REQ-023 reg_addr, wr_data and wr_msk SHALL be registered, stable from ISSUE through the end of RD_WAIT, and hold their last value while idle.
REQ-024 mN_rdata SHALL hold until that requester's next read completes; the non-owner's rvalid and rdata SHALL not change.
REQ-025 Latency: gnt at cycle T; strobe at T+1; read rvalid at T+1+RD_LAT.
REQ-026 Throughput: one write per 2 cycles; one read per 2+RD_LAT cycles.
REQ-027 Arbitration: if only one requester asserts req, it SHALL be granted; if both assert req, the requester not granted last SHALL win.
REQ-028 The last-grant pointer SHALL update on every gnt; after reset it points to m1, so m0 wins the first tie.
REQ-029 Requests arriving outside IDLE SHALL wait, with no loss and no gnt.
REQ-030 A req dropped before gnt SHALL be ignored, with no side effects.

Reset
REQ-031 presetn low SHALL immediately force state IDLE, all outputs 0, and pointer = m1.
REQ-032 Reset mid-ISSUE or mid-RD_WAIT SHALL abort the in-flight access with no rvalid; operation resumes from IDLE on the first edge after release.

Configuration
REQ-033 Macro REG_ARB_FIXED_PRIO_EN defined: m0 SHALL always win ties; pointer logic is removed.
REQ-034 Macro REG_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-027/REQ-028 SHALL apply.

Verification
REQ-035 m0 write 0x010 = 0xA5A5_0001, wmsk 0xF -> m0_gnt at T; wr_en=1, reg_addr=0x010, wr_data=0xA5A5_0001, wr_msk=0xF at T+1; rd_en=0 throughout.
REQ-036 RD_LAT=2; m1 read 0x020; rd_data=0x1234_5678 at T+3 -> rd_en at T+1; m1_rvalid=1 and m1_rdata=0x1234_5678 at T+3; m0_rvalid stays 0.
REQ-037 Round-robin build, both req held for 4 grants after reset -> grant order m0, m1, m0, m1, grants 2 cycles apart for writes.
REQ-038 REG_ARB_FIXED_PRIO_EN build, same stimulus -> m0 granted 4 times before m1 receives any gnt.
REQ-039 presetn pulled low in RD_WAIT of an m0 read -> outputs 0 immediately; no m0_rvalid; next m0 read after release completes normally.
REQ-040 m1_req asserted during m0 RD_WAIT -> no m1_gnt until the m0_rvalid cycle has passed; m1_gnt in the next IDLE cycle.
